// File: rtl/mem_pkg.sv
// Shared constants for the distributed data memory controller: default widths,
// memory depth and FSM state encoding.
package mem_pkg;

    localparam int ADDR_W    = 10;
    localparam int DATA_W    = 16;
    localparam int LEN_W     = 4;
    localparam int MEM_DEPTH = 1024;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WRITE  = 2'd1;
    localparam logic [1:0] ST_READ   = 2'd2;
    localparam logic [1:0] ST_VERIFY = 2'd3;

endpackage

// File: rtl/mem_access_ctrl.sv
// Initiator-side controller for the 1024x16 distributed data memory: single-word
// writes and 1-16 word burst reads. Optional write read-back check: MEM_WRITE_VERIFY_EN.
module mem_access_ctrl #(
    parameter int ADDR_W = mem_pkg::ADDR_W,
    parameter int DATA_W = mem_pkg::DATA_W,
    parameter int LEN_W  = mem_pkg::LEN_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [LEN_W-1:0]  req_len,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_last,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_d,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_spo,
    output logic [1:0]        dbg_state
`ifdef MEM_WRITE_VERIFY_EN
    ,
    output logic              verify_err
`endif
);

    import mem_pkg::*;

    logic [1:0]        state;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [LEN_W-1:0]  cnt_q;

    // Handshake: a request transfers on a rising edge where req_valid && req_ready.
    // Ready is high only in IDLE (and never during reset); the requester holds its
    // request until it transfers. Responses have no backpressure.
    assign req_ready = (state == ST_IDLE) && !reset;
    assign busy      = (state != ST_IDLE);
    assign mem_a     = addr_q;
    assign mem_d     = wdata_q;
    assign mem_we    = (state == ST_WRITE);
    assign dbg_state = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            rsp_valid <= 1'b0;
            rsp_last  <= 1'b0;
            rsp_data  <= '0;
`ifdef MEM_WRITE_VERIFY_EN
            verify_err <= 1'b0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            rsp_last  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        cnt_q   <= req_len;
                        state   <= req_we ? ST_WRITE : ST_READ;
                    end
                end
                ST_WRITE: begin
`ifdef MEM_WRITE_VERIFY_EN
                    state <= ST_VERIFY;
`else
                    rsp_valid <= 1'b1;
                    rsp_last  <= 1'b1;
                    rsp_data  <= wdata_q;
                    state     <= ST_IDLE;
`endif
                end
`ifdef MEM_WRITE_VERIFY_EN
                ST_VERIFY: begin
                    // The ack carries what the memory actually returned.
                    rsp_valid <= 1'b1;
                    rsp_last  <= 1'b1;
                    rsp_data  <= mem_spo;
                    if (mem_spo != wdata_q) begin
                        verify_err <= 1'b1;
                    end
                    state <= ST_IDLE;
                end
`endif
                ST_READ: begin
                    rsp_valid <= 1'b1;
                    rsp_data  <= mem_spo;
                    rsp_last  <= (cnt_q == '0);
                    addr_q    <= addr_q + 1'b1;
                    cnt_q     <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: memory model, reference word array and
// expected-beat queue; run with MEM_WRITE_VERIFY_EN defined to cover the read-back check.
module tb_mem_access_ctrl;

    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [9:0]  req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic [3:0]  req_len = '0;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_last;
    logic        busy;
    logic [9:0]  mem_a;
    logic [15:0] mem_d;
    logic        mem_we;
    logic [15:0] mem_spo;
    logic [1:0]  dbg_state;
`ifdef MEM_WRITE_VERIFY_EN
    logic        verify_err;
    logic        exp_err = 1'b0;
`endif

    int n_vec = 0;
    int n_err = 0;

    // Memory environment (the DistributedMemory stand-in) and the reference contents.
    logic [15:0] mem     [1024];
    logic [15:0] ref_mem [1024];
    logic        corrupt_en = 1'b0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem[mem_a] <= mem_d;
    end
    assign mem_spo = (corrupt_en && mem_a == 10'd5) ? 16'h0000 : mem[mem_a];

    mem_access_ctrl dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last),
        .busy(busy), .mem_a(mem_a), .mem_d(mem_d), .mem_we(mem_we),
        .mem_spo(mem_spo), .dbg_state(dbg_state)
`ifdef MEM_WRITE_VERIFY_EN
        , .verify_err(verify_err)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int b = 0;
        while (req_ready !== 1'b1 && b < 50) begin
            step();
            b++;
        end
        n_vec++;
        if (req_ready !== 1'b1) begin
            $display("FAIL ready_timeout got %b exp 1", req_ready);
            n_err++;
        end
    endtask

    task automatic do_write(input logic [9:0] addr, input logic [15:0] data);
        logic [15:0] exp_data;
        wait_ready();
        req_valid = 1'b1; req_we = 1'b1; req_addr = addr; req_wdata = data;
        req_len = 4'($urandom_range(0, 15));
        step();
        req_valid = 1'b0;
        n_vec++;
        if ({mem_we, mem_a, mem_d, rsp_valid, busy, req_ready} !== {1'b1, addr, data, 1'b0, 1'b1, 1'b0}) begin
            $display("FAIL write_pins got we=%b a=%h d=%h rv=%b busy=%b rdy=%b exp we=1 a=%h d=%h rv=0 busy=1 rdy=0",
                     mem_we, mem_a, mem_d, rsp_valid, busy, req_ready, addr, data);
            n_err++;
        end
        ref_mem[addr] = data;
        exp_data = data;
`ifdef MEM_WRITE_VERIFY_EN
        step();
        n_vec++;
        if ({mem_we, mem_a, rsp_valid, busy} !== {1'b0, addr, 1'b0, 1'b1}) begin
            $display("FAIL verify_pins got we=%b a=%h rv=%b busy=%b exp we=0 a=%h rv=0 busy=1",
                     mem_we, mem_a, rsp_valid, busy, addr);
            n_err++;
        end
        exp_data = (corrupt_en && addr == 10'd5) ? 16'h0000 : data;
        if (exp_data != data) exp_err = 1'b1;
`endif
        step();
        n_vec++;
        if ({rsp_valid, rsp_last, rsp_data, mem_we, req_ready, busy} !== {1'b1, 1'b1, exp_data, 1'b0, 1'b1, 1'b0}) begin
            $display("FAIL write_ack got rv=%b rl=%b data=%h we=%b rdy=%b busy=%b exp rv=1 rl=1 data=%h we=0 rdy=1 busy=0",
                     rsp_valid, rsp_last, rsp_data, mem_we, req_ready, busy, exp_data);
            n_err++;
        end
`ifdef MEM_WRITE_VERIFY_EN
        n_vec++;
        if (verify_err !== exp_err) begin
            $display("FAIL verify_err got %b exp %b", verify_err, exp_err);
            n_err++;
        end
`endif
    endtask

    task automatic do_read(input logic [9:0] addr, input int len);
        logic [15:0] exp;
        wait_ready();
        req_valid = 1'b1; req_we = 1'b0; req_addr = addr; req_len = 4'(len);
        req_wdata = 16'($urandom);
        for (int i = 0; i <= len; i++) exp_q.push_back(ref_mem[(int'(addr) + i) % MEM_DEPTH]);
        step();
        req_valid = 1'b0;
        n_vec++;
        if ({mem_we, busy, rsp_valid, mem_a} !== {1'b0, 1'b1, 1'b0, addr}) begin
            $display("FAIL read_start got we=%b busy=%b rv=%b a=%h exp we=0 busy=1 rv=0 a=%h",
                     mem_we, busy, rsp_valid, mem_a, addr);
            n_err++;
        end
        for (int i = 0; i <= len; i++) begin
            step();
            exp = exp_q.pop_front();
            n_vec++;
            if ({rsp_valid, rsp_last, rsp_data} !== {1'b1, (i == len), exp}) begin
                $display("FAIL read_beat%0d addr=%h got rv=%b rl=%b data=%h exp rv=1 rl=%b data=%h",
                         i, addr, rsp_valid, rsp_last, rsp_data, (i == len), exp);
                n_err++;
            end
        end
        n_vec++;
        if ({req_ready, busy} !== 2'b10) begin
            $display("FAIL read_end got rdy=%b busy=%b exp rdy=1 busy=0", req_ready, busy);
            n_err++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        n_vec++;
        if ({mem_we, rsp_valid, rsp_last, busy, mem_a, mem_d, rsp_data, req_ready} !== '0) begin
            $display("FAIL reset_outputs got we=%b rv=%b rl=%b busy=%b a=%h d=%h data=%h rdy=%b exp all 0",
                     mem_we, rsp_valid, rsp_last, busy, mem_a, mem_d, rsp_data, req_ready);
            n_err++;
        end
`ifdef MEM_WRITE_VERIFY_EN
        exp_err = 1'b0;
        n_vec++;
        if (verify_err !== 1'b0) begin
            $display("FAIL reset_verify_err got %b exp 0", verify_err);
            n_err++;
        end
`endif
        reset = 1'b0;
        #1;
        n_vec++;
        if ({req_ready, busy} !== 2'b10) begin
            $display("FAIL reset_release got rdy=%b busy=%b exp rdy=1 busy=0", req_ready, busy);
            n_err++;
        end
    endtask

    task automatic test_write();
        do_write(10'd1, 16'hFFFF);
    endtask

    task automatic test_single_reads();
        do_write(10'd3, 16'h2222);
        do_write(10'd11, 16'hEFAB);
        do_read(10'd3, 0);
        do_read(10'd11, 0);
    endtask

    task automatic test_burst_wrap();
        do_write(10'd1022, 16'($urandom));
        do_write(10'd1023, 16'($urandom));
        do_write(10'd0, 16'($urandom));
        do_read(10'd1022, 3);
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp;
        wait_ready();
        req_valid = 1'b1; req_we = 1'b0; req_addr = 10'd200; req_len = 4'd3;
        for (int i = 0; i < 4; i++) exp_q.push_back(ref_mem[200 + i]);
        step();
        // A second request is held during the burst and must wait for IDLE.
        req_addr = 10'd600; req_len = 4'd0;
        for (int i = 0; i < 4; i++) begin
            step();
            exp = exp_q.pop_front();
            n_vec++;
            if ({rsp_valid, rsp_last, rsp_data, req_ready} !== {1'b1, (i == 3), exp, (i == 3)}) begin
                $display("FAIL held_req_beat%0d got rv=%b rl=%b data=%h rdy=%b exp rv=1 rl=%b data=%h rdy=%b",
                         i, rsp_valid, rsp_last, rsp_data, req_ready, (i == 3), exp, (i == 3));
                n_err++;
            end
        end
        step();
        req_valid = 1'b0;
        n_vec++;
        if ({rsp_valid, busy, mem_a} !== {1'b0, 1'b1, 10'd600}) begin
            $display("FAIL held_req_accept got rv=%b busy=%b a=%h exp rv=0 busy=1 a=258",
                     rsp_valid, busy, mem_a);
            n_err++;
        end
        step();
        n_vec++;
        if ({rsp_valid, rsp_last, rsp_data} !== {1'b1, 1'b1, ref_mem[600]}) begin
            $display("FAIL held_req_beat got rv=%b rl=%b data=%h exp rv=1 rl=1 data=%h",
                     rsp_valid, rsp_last, rsp_data, ref_mem[600]);
            n_err++;
        end
        step();
        n_vec++;
        if ({rsp_valid, busy} !== 2'b00) begin
            $display("FAIL held_req_extra got rv=%b busy=%b exp rv=0 busy=0", rsp_valid, busy);
            n_err++;
        end
    endtask

    task automatic test_reset_mid_burst();
        wait_ready();
        req_valid = 1'b1; req_we = 1'b0; req_addr = 10'd40; req_len = 4'd15;
        step();
        req_valid = 1'b0;
        step();
        step();
        n_vec++;
        if ({rsp_valid, rsp_data} !== {1'b1, ref_mem[41]}) begin
            $display("FAIL abort_second_beat got rv=%b data=%h exp rv=1 data=%h", rsp_valid, rsp_data, ref_mem[41]);
            n_err++;
        end
        reset = 1'b1;
        #1;
        n_vec++;
        if ({rsp_valid, rsp_last, busy, mem_we, req_ready} !== 5'b0) begin
            $display("FAIL abort_outputs got rv=%b rl=%b busy=%b we=%b rdy=%b exp all 0",
                     rsp_valid, rsp_last, busy, mem_we, req_ready);
            n_err++;
        end
`ifdef MEM_WRITE_VERIFY_EN
        exp_err = 1'b0;
`endif
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            n_vec++;
            if (rsp_valid !== 1'b0) begin
                $display("FAIL abort_no_beats got rv=%b exp 0", rsp_valid);
                n_err++;
            end
        end
        do_read(10'd0, 0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 1) == 1) do_write(10'($urandom), 16'($urandom));
            else do_read(10'($urandom), int'($urandom_range(0, 15)));
        end
    endtask

`ifdef MEM_WRITE_VERIFY_EN
    task automatic test_verify();
        corrupt_en = 1'b1;
        do_write(10'd5, 16'h1234);
        do_write(10'd7, 16'hABCD);
        corrupt_en = 1'b0;
        do_write(10'd9, 16'h5A5A);
        test_reset();
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < MEM_DEPTH; i++) begin
            mem[i]     = 16'($urandom);
            ref_mem[i] = mem[i];
        end
        test_reset();
        test_write();
        test_single_reads();
        test_burst_wrap();
        test_back_to_back();
        test_reset_mid_burst();
        test_random();
`ifdef MEM_WRITE_VERIFY_EN
        test_verify();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
